// File: rtl/port_io_controller.sv
// -----------------------------------------------------------------------------
// port_io_controller
//
// Peripheral-side partner of the CPU output-port and input-port registers.
//
//   Outbound: every word the CPU writes to its output port (cpu_out_load) is
//   captured into a small first-word-fall-through FIFO. The FIFO is drained
//   to an external device over a valid/ready handshake.
//
//   Inbound: one word is accepted from an external device over valid/ready.
//   It is held on cpu_in_data until the CPU pulses cpu_in_read.
//
// Ports
//   clock          system clock, all state changes on the rising edge
//   clear          synchronous active-high reset, overrides every other input
//   cpu_bus_data   CPU bus value, sampled when cpu_out_load=1
//   cpu_out_load   CPU output-port write enable
//   cpu_in_read    CPU input-port read strobe; one pulse consumes one word
//   cpu_in_data    inbound holding register, drives the CPU input port
//   cpu_in_full    inbound holding register holds an unread word
//   dev_out_data   FIFO head word; holds the last popped word when empty
//   dev_out_valid  FIFO non-empty
//   dev_out_ready  device takes the head word this cycle
//   dev_in_data    device word
//   dev_in_valid   device offers a word
//   dev_in_ready   controller accepts a word this cycle (registered decode)
//   out_count      outbound FIFO occupancy
//   out_ovf        sticky flag: an outbound word was dropped
//   out_drop_cnt   saturating count of dropped outbound words
//                  (present only when PORT_IO_DROP_COUNT_EN is defined)
//
// Build option
//   PORT_IO_DROP_COUNT_EN : adds out_drop_cnt; out_ovf is then derived from it.
// -----------------------------------------------------------------------------
module port_io_controller #(
  parameter int DATA_W    = 32,
  parameter int OUT_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         clear,
  input  logic [DATA_W-1:0]            cpu_bus_data,
  input  logic                         cpu_out_load,
  input  logic                         cpu_in_read,
  output logic [DATA_W-1:0]            cpu_in_data,
  output logic                         cpu_in_full,
  output logic [DATA_W-1:0]            dev_out_data,
  output logic                         dev_out_valid,
  input  logic                         dev_out_ready,
  input  logic [DATA_W-1:0]            dev_in_data,
  input  logic                         dev_in_valid,
  output logic                         dev_in_ready,
  output logic [$clog2(OUT_DEPTH):0]   out_count,
`ifdef PORT_IO_DROP_COUNT_EN
  output logic                         out_ovf,
  output logic [7:0]                   out_drop_cnt
`else
  output logic                         out_ovf
`endif
);

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // Outbound FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_inc;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [DATA_W-1:0] head_reg, head_next;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              drop;

  assign fifo_full  = (count_reg == CNT_W'(OUT_DEPTH));
  assign pop        = (count_reg != '0) && dev_out_ready;
  // A coincident pop frees a slot, so a write at full is still accepted.
  assign push       = cpu_out_load && (!fifo_full || pop);
  assign drop       = cpu_out_load && fifo_full && !pop;
  assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

  always_comb begin
    wr_ptr_next = push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_inc             : rd_ptr_reg;
    count_next  = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // head_reg is the registered read port of the FIFO. It is reloaded whenever
  // the head entry changes. When the FIFO goes empty it keeps the last popped
  // word. The new head comes straight from the bus when the incoming word
  // becomes the head: an empty FIFO, or the only entry being popped.
  always_comb begin
    head_next = head_reg;
    if (count_next != '0) begin
      if ((count_reg == '0) || (pop && (count_reg == CNT_W'(1)))) begin
        head_next = cpu_bus_data;
      end else if (pop) begin
        head_next = mem[rd_ptr_inc];
      end
    end
  end

  // Storage array carries no reset; the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= cpu_bus_data;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  assign dev_out_data  = head_reg;
  assign dev_out_valid = (count_reg != '0);
  assign out_count     = count_reg;

  // ---------------------------------------------------------------------------
  // Drop reporting
  // ---------------------------------------------------------------------------
`ifdef PORT_IO_DROP_COUNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clock) begin
    if (clear) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign out_drop_cnt = drop_cnt_reg;
  assign out_ovf      = (drop_cnt_reg != 8'd0);
`else
  logic ovf_reg;

  always_ff @(posedge clock) begin
    if (clear) begin
      ovf_reg <= 1'b0;
    end else if (drop) begin
      ovf_reg <= 1'b1;
    end
  end

  assign out_ovf = ovf_reg;
`endif

  // ---------------------------------------------------------------------------
  // Inbound path: two-state FSM plus holding register
  // ---------------------------------------------------------------------------
  typedef enum logic {
    IN_EMPTY = 1'b0,
    IN_FULL  = 1'b1
  } in_state_t;

  in_state_t         in_state_reg, in_state_next;
  logic [DATA_W-1:0] in_data_reg;

  // State register
  always_ff @(posedge clock) begin
    if (clear) begin
      in_state_reg <= IN_EMPTY;
    end else begin
      in_state_reg <= in_state_next;
    end
  end

  // Next-state logic. A read in IN_FULL only returns to IN_EMPTY, so a word
  // offered in that same cycle waits for the following edge.
  always_comb begin
    in_state_next = in_state_reg;
    case (in_state_reg)
      IN_EMPTY: if (dev_in_valid) in_state_next = IN_FULL;
      IN_FULL:  if (cpu_in_read)  in_state_next = IN_EMPTY;
      default:  in_state_next = IN_EMPTY;
    endcase
  end

  // Output decode. It depends only on the state register, so dev_in_ready has
  // no combinational path from dev_in_valid.
  always_comb begin
    dev_in_ready = 1'b0;
    cpu_in_full  = 1'b0;
    case (in_state_reg)
      IN_EMPTY: dev_in_ready = 1'b1;
      IN_FULL:  cpu_in_full  = 1'b1;
      default:  dev_in_ready = 1'b0;
    endcase
  end

  // Holding register keeps its value after a read (stale data stays visible).
  always_ff @(posedge clock) begin
    if (clear) begin
      in_data_reg <= '0;
    end else if ((in_state_reg == IN_EMPTY) && dev_in_valid) begin
      in_data_reg <= dev_in_data;
    end
  end

  assign cpu_in_data = in_data_reg;

endmodule

// File: doc/port_io_controller.md
Name: port_io_controller

Overview:
- Peripheral-side partner of the CPU's Out_Port and In_port registers.
- Outbound path: captures every word the CPU writes to its output port into a small FIFO. Drains that FIFO to an external device over a valid/ready handshake.
- Inbound path: accepts one word from an external device over valid/ready, holds it on the CPU input-port data lines, and releases it when the CPU reads the input port.
- Sits between the datapath top level (bus, Out_portIn, InPortout) and off-chip/testbench devices.

Parameters:
- DATA_W, 32, width of every data word.
- OUT_DEPTH, 4, outbound FIFO entries; power of two, >= 2.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- clear  input  1  reset, synchronous, active-high.
- cpu_bus_data  input  DATA_W  CPU bus value (BusMuxOut).
- cpu_out_load  input  1  CPU output-port write enable (Out_portIn).
- cpu_in_read  input  1  CPU input-port read strobe (InPortout); one pulse = one consume.
- cpu_in_data  output  DATA_W  drives CPU Inport_In.
- cpu_in_full  output  1  inbound holding register holds an unread word.
- dev_out_data  output  DATA_W  FIFO head word.
- dev_out_valid  output  1  FIFO non-empty.
- dev_out_ready  input  1  device accepts head word this cycle.
- dev_in_data  input  DATA_W  device word.
- dev_in_valid  input  1  device offers a word.
- dev_in_ready  output  1  controller accepts a word this cycle.
- out_count  output  $clog2(OUT_DEPTH)+1  current outbound FIFO occupancy.
- out_ovf  output  1  sticky: an outbound word was dropped.

Behaviour:
- Reset (clear=1 at an edge):
  - cpu_in_data=0, cpu_in_full=0, dev_in_ready=1.
  - FIFO emptied: out_count=0, dev_out_valid=0, dev_out_data=0.
  - out_ovf=0; in-FSM goes to IN_EMPTY.
  - Clear mid-transfer discards all pending words with no handshake completion.
  - clear has priority over every other input in the same cycle.
- Outbound capture:
  - cpu_bus_data is sampled on the same edge as the CPU Out_Port register when cpu_out_load=1, so the FIFO receives exactly the value the port latches.
  - Pushed word is visible at dev_out_data/dev_out_valid in the cycle after the capture edge (1-cycle latency).
- Outbound drain:
  - dev_out_valid = (out_count != 0). dev_out_data = head entry, first-word-fall-through. Head is held stable while valid && !ready.
  - Pop occurs when dev_out_valid && dev_out_ready at the edge.
  - dev_out_data holds the last popped value when the FIFO is empty. dev_out_valid is the qualifier.
- FIFO boundaries:
  - Push and pop in the same cycle: both performed, out_count unchanged. This applies at full too, so a word is accepted when full if a pop coincides.
  - Push when full with no pop: word dropped, FIFO unchanged, out_ovf set to 1 and held until clear.
  - Pop when empty cannot occur because valid=0.
  - Read and write pointers are $clog2(OUT_DEPTH) bits and wrap modulo OUT_DEPTH.
- Inbound FSM has two states:
  - IN_EMPTY: dev_in_ready=1. If dev_in_valid=1 at an edge, cpu_in_data<=dev_in_data and the FSM goes to IN_FULL.
  - IN_FULL: dev_in_ready=0, cpu_in_full=1. If cpu_in_read=1 at an edge, go to IN_EMPTY.
- Inbound rules:
  - cpu_in_data is NOT cleared on read and keeps its last value.
  - No pass-through: a word offered in the cycle the read occurs is accepted no earlier than the following edge.
  - cpu_in_read in IN_EMPTY is ignored. The CPU then reads the stale cpu_in_data, and state is unchanged.
  - dev_in_ready is a registered state decode with no combinational path from dev_in_valid.
- The outbound and inbound paths are fully independent and may both act in the same cycle.

Optional Feature:
- Macro: PORT_IO_DROP_COUNT_EN.
- Defined:
  - Adds output port out_drop_cnt [7:0].
  - Increments by 1 on each dropped outbound word, saturating at 8'hFF. Reset value 0.
  - out_ovf remains and equals (out_drop_cnt != 0).
- Undefined: port and counter absent; out_ovf alone reports drops.

Test Plan:
- Reset then single write: clear 1 cycle; cpu_out_load=1 with bus=32'h0000_00A5, dev_out_ready=0 -> next cycle dev_out_valid=1, dev_out_data=32'hA5, out_count=1. Raise ready -> one pop, valid=0, count=0.
- Fill and overflow (OUT_DEPTH=4): write 1,2,3,4,5 on consecutive cycles, ready=0 -> count=4, out_ovf=1. Drain with ready=1 -> data sequence 1,2,3,4, and 5 never appears. With PORT_IO_DROP_COUNT_EN, out_drop_cnt=1.
- Full with simultaneous push/pop: FIFO holds 1..4; one cycle with load=1 (bus=6) and ready=1 -> count stays 4, out_ovf=0; subsequent drain yields 2,3,4,6.
- Inbound handshake: dev_in_valid=1, dev_in_data=32'h1234_5678 -> after edge cpu_in_full=1, cpu_in_data=32'h12345678, dev_in_ready=0. A second word 32'hDEAD_BEEF held valid stays un-accepted until a cpu_in_read pulse. After that, ready=1 for one cycle and the following edge captures 32'hDEADBEEF.
- Read when empty and data retention: after consume, cpu_in_read pulses again with no device valid -> state stays IN_EMPTY, cpu_in_data still 32'hDEADBEEF.
- Reset mid-operation: FIFO count=3 and inbound full; assert clear together with load and dev_in_valid -> next cycle count=0, dev_out_valid=0, cpu_in_full=0, cpu_in_data=0, out_ovf=0; the coincident load and device word are both discarded.
